// File: rtl/bb_feeder_pkg.sv
// Shared types and constants for the accumulator operand feeder.
package bb_feeder_pkg;

    localparam int A_WIDTH    = 8;
    localparam int B_WIDTH    = 16;
    localparam int REP_WIDTH  = 8;
    localparam int CNT_WIDTH  = 16;
    localparam int FIFO_DEPTH = 4;

    // One queued command: operand pair plus the number of cycles to drive it.
    typedef struct packed {
        logic [A_WIDTH-1:0]   a;
        logic [B_WIDTH-1:0]   b;
        logic [REP_WIDTH-1:0] rep;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_width(input int d);
        return (d <= 2) ? 1 : $clog2(d);
    endfunction

    localparam int FIFO_PTR_W = ptr_width(FIFO_DEPTH);

endpackage

// File: rtl/bb_cmd_fifo.sv
// Small synchronous command FIFO with flush. Head data is read straight from
// storage; count/full/empty all come from the registered occupancy count.
module bb_cmd_fifo
    import bb_feeder_pkg::*;
#(
    parameter int DW      = CMD_W,
    parameter int DEPTH_P = FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [DW-1:0]               push_data,
    input  logic                        pop,
    output logic [DW-1:0]               head,
    output logic [ptr_width(DEPTH_P):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int PW = ptr_width(DEPTH_P);
    localparam logic [PW:0]   FULL_CNT = DEPTH_P[PW:0];
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE  = 1;

    logic [DW-1:0] mem_q [DEPTH_P];
    logic [DW-1:0] mem_d [DEPTH_P];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and storage; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push & ~full & ~flush;
        do_pop   = pop & ~empty & ~flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Control state: cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bb_operand_feeder.sv
// Operand feeder for the dual-accumulator: queues {a, b, repeat} commands and
// drives each pair for `repeat` consecutive cycles, zero otherwise.
module bb_operand_feeder
    import bb_feeder_pkg::*;
#(
    parameter int aWidth   = A_WIDTH,
    parameter int bWidth   = B_WIDTH,
    parameter int depth    = FIFO_DEPTH,
    parameter int repWidth = REP_WIDTH,
    parameter int cntWidth = CNT_WIDTH
) (
    input  logic                io_clockPin,
    input  logic                io_resetPin,
    input  logic                io_flush,
    input  logic                io_cmd_valid,
    output logic                io_cmd_ready,
    input  logic [aWidth-1:0]   io_cmd_a,
    input  logic [bWidth-1:0]   io_cmd_b,
    input  logic [repWidth-1:0] io_cmd_repeat,
    output logic [aWidth-1:0]   io_outA,
    output logic [bWidth-1:0]   io_outB,
    output logic                io_outFire,
    output logic                io_busy,
    output logic [cntWidth-1:0] io_issuedCount
);

    localparam int ENTRY_W = aWidth + bWidth + repWidth;
    localparam int PW      = ptr_width(depth);
    localparam logic [PW:0]         ONE_ENTRY = 1;
    localparam logic [repWidth-1:0] REP_ONE   = 1;
    localparam logic [cntWidth-1:0] CNT_ONE   = 1;

    logic [ENTRY_W-1:0]  fifo_head;
    logic [PW:0]         fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                avail;
    logic [aWidth-1:0]   head_a;
    logic [bWidth-1:0]   head_b;
    logic [repWidth-1:0] head_rep;

    logic [repWidth-1:0] rem_q, rem_d;
    logic [aWidth-1:0]   out_a_q, out_a_d;
    logic [bWidth-1:0]   out_b_q, out_b_d;
    logic                fire_q, fire_d;
    logic [cntWidth-1:0] cnt_q, cnt_d;
    logic                last_push_q, last_push_d;

    assign io_cmd_ready = ~fifo_full & ~io_flush & ~io_resetPin;
    assign push         = io_cmd_valid & io_cmd_ready;

    assign head_a   = fifo_head[ENTRY_W-1 -: aWidth];
    assign head_b   = fifo_head[repWidth +: bWidth];
    assign head_rep = fifo_head[repWidth-1:0];

    // An entry becomes poppable one cycle after it was written: the entry
    // pushed at the last edge is hidden from the issue logic for one cycle.
    assign avail = (fifo_count != '0) && !(last_push_q && (fifo_count == ONE_ENTRY));

    bb_cmd_fifo #(
        .DW      (ENTRY_W),
        .DEPTH_P (depth)
    ) u_fifo (
        .clk       (io_clockPin),
        .rst       (io_resetPin),
        .flush     (io_flush),
        .push      (push),
        .push_data ({io_cmd_a, io_cmd_b, io_cmd_repeat}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue FSM: rem counts cycles still owed after the current one; at
    // rem==0 the next command is loaded (or the outputs drop to zero).
    always_comb begin
        rem_d       = rem_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        fire_d      = fire_q;
        pop         = 1'b0;
        last_push_d = push;
        cnt_d       = fire_q ? (cnt_q + CNT_ONE) : cnt_q;
        if (io_flush) begin
            rem_d       = '0;
            out_a_d     = '0;
            out_b_d     = '0;
            fire_d      = 1'b0;
            last_push_d = 1'b0;
        end else if (rem_q != '0) begin
            rem_d = rem_q - REP_ONE;
        end else begin
            out_a_d = '0;
            out_b_d = '0;
            fire_d  = 1'b0;
            if (avail) begin
                pop = 1'b1;
                if (head_rep != '0) begin
                    out_a_d = head_a;
                    out_b_d = head_b;
                    fire_d  = 1'b1;
                    rem_d   = head_rep - REP_ONE;
                end
            end
        end
    end

    // Issue state and registered outputs; reset clears everything at once.
    always_ff @(posedge io_clockPin or posedge io_resetPin) begin
        if (io_resetPin) begin
            rem_q       <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            fire_q      <= 1'b0;
            cnt_q       <= '0;
            last_push_q <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            fire_q      <= fire_d;
            cnt_q       <= cnt_d;
            last_push_q <= last_push_d;
        end
    end

    assign io_outA        = out_a_q;
    assign io_outB        = out_b_q;
    assign io_outFire     = fire_q;
    assign io_issuedCount = cnt_q;
    assign io_busy        = ~fifo_empty | (rem_q != '0) | fire_q;

endmodule

// File: tb/tb_bb_operand_feeder.sv
// Directed bench for bb_operand_feeder with hand-computed expectations.
module tb_bb_operand_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid;
    logic        ready;
    logic [7:0]  a;
    logic [15:0] b;
    logic [7:0]  rep;
    logic [7:0]  out_a;
    logic [15:0] out_b;
    logic        out_fire;
    logic        busy;
    logic [15:0] issued;

    int n_chk = 0;
    int n_err = 0;
    int unsigned acc_a = 0;
    int unsigned acc_b = 0;

    bb_operand_feeder dut (
        .io_clockPin    (clk),
        .io_resetPin    (rst),
        .io_flush       (flush),
        .io_cmd_valid   (valid),
        .io_cmd_ready   (ready),
        .io_cmd_a       (a),
        .io_cmd_b       (b),
        .io_cmd_repeat  (rep),
        .io_outA        (out_a),
        .io_outB        (out_b),
        .io_outFire     (out_fire),
        .io_busy        (busy),
        .io_issuedCount (issued)
    );

    always #5 clk = ~clk;

    // Downstream accumulator model: adds whatever is on the outputs each cycle.
    always @(negedge clk) begin
        acc_a <= acc_a + 32'(out_a);
        acc_b <= acc_b + 32'(out_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [7:0] ca, input logic [15:0] cb, input logic [7:0] cr,
                         output logic took);
        a     = ca;
        b     = cb;
        rep   = cr;
        valid = 1'b1;
        took  = ready;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        took;
        int unsigned sa, sb;
        int          n;
        logic [7:0]  seen[$];
        logic [7:0]  exp_a5[5];
        logic [7:0]  exp_f[5];
        logic [7:0]  exp_x[5];
        logic [15:0] exp_y[5];

        rst = 1'b1; flush = 1'b0; valid = 1'b0; a = '0; b = '0; rep = '0;
        tick(); tick();
        check("rst_outA", 32'(out_a), 0);
        check("rst_outB", 32'(out_b), 0);
        check("rst_fire", 32'(out_fire), 0);
        check("rst_count", 32'(issued), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(ready), 0);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(ready), 1);
        tick();

        // Test 1: single command (3,5,4); fire for 4 cycles after edge t+2.
        sa = acc_a; sb = acc_b;
        offer(8'd3, 16'd5, 8'd4, took);
        check("t1_accept", 32'(took), 1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t1_fire%0d", i), 32'(out_fire), (i >= 2 && i <= 5) ? 1 : 0);
            check($sformatf("t1_a%0d", i), 32'(out_a), (i >= 2 && i <= 5) ? 3 : 0);
            check($sformatf("t1_b%0d", i), 32'(out_b), (i >= 2 && i <= 5) ? 5 : 0);
            if (i == 1) check("t1_busy", 32'(busy), 1);
            tick();
        end
        check("t1_count", 32'(issued), 4);
        check("t1_accA", acc_a - sa, 12);
        check("t1_accB", acc_b - sb, 20);

        // Test 2: back-to-back (1,2,1) then (7,9,2).
        sa = acc_a; sb = acc_b;
        exp_f = '{0, 1, 1, 1, 0};
        exp_x = '{0, 1, 7, 7, 0};
        exp_y = '{0, 2, 9, 9, 0};
        offer(8'd1, 16'd2, 8'd1, took);
        offer(8'd7, 16'd9, 8'd2, took);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_fire%0d", i), 32'(out_fire), 32'(exp_f[i]));
            check($sformatf("t2_a%0d", i), 32'(out_a), 32'(exp_x[i]));
            check($sformatf("t2_b%0d", i), 32'(out_b), 32'(exp_y[i]));
            tick();
        end
        check("t2_accA", acc_a - sa, 15);
        check("t2_accB", acc_b - sb, 20);
        check("t2_count", 32'(issued), 7);

        // Test 3: long issue, fill the FIFO, 5th command waits for the first pop.
        offer(8'd1, 16'd1, 8'd200, took);
        check("t3_acc0", 32'(took), 1);
        for (int i = 0; i < 4; i++) begin
            offer(8'(10 + i), 16'(110 + i), 8'd1, took);
            check($sformatf("t3_acc%0d", i + 1), 32'(took), 1);
        end
        check("t3_full_ready", 32'(ready), 0);
        a = 8'd14; b = 16'd114; rep = 8'd1; valid = 1'b1;
        n = 0;
        while (!ready && n < 300) begin
            tick();
            n++;
        end
        check("t3_wait", n, 198);
        check("t3_first_pop", 32'(out_a), 10);
        if (out_fire) seen.push_back(out_a);
        tick();
        valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_fire) seen.push_back(out_a);
            tick();
        end
        exp_a5 = '{10, 11, 12, 13, 14};
        check("t3_nseen", seen.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_seq%0d", i), (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF,
                  32'(exp_a5[i]));
        end
        check("t3_count", 32'(issued), 212);

        // Test 4: rep=0 entry is consumed silently, then (2,2,1) fires once.
        offer(8'd5, 16'd5, 8'd0, took);
        offer(8'd2, 16'd2, 8'd1, took);
        check("t4_fire_w1", 32'(out_fire), 0);
        tick();
        check("t4_fire_zero", 32'(out_fire), 0);
        check("t4_a_zero", 32'(out_a), 0);
        check("t4_busy", 32'(busy), 1);
        tick();
        check("t4_fire", 32'(out_fire), 1);
        check("t4_a", 32'(out_a), 2);
        check("t4_b", 32'(out_b), 2);
        tick();
        check("t4_fire_end", 32'(out_fire), 0);
        check("t4_count", 32'(issued), 213);
        check("t4_idle", 32'(busy), 0);

        // Test 5: flush during (4,4,10) with two entries queued.
        offer(8'd4, 16'd4, 8'd10, took);
        offer(8'd6, 16'd6, 8'd1, took);
        offer(8'd8, 16'd8, 8'd1, took);
        check("t5_fire", 32'(out_fire), 1);
        check("t5_a", 32'(out_a), 4);
        tick();
        check("t5_count_pre", 32'(issued), 214);
        flush = 1'b1;
        a = 8'd9; b = 16'd9; rep = 8'd1; valid = 1'b1;
        #1;
        check("t5_ready_flush", 32'(ready), 0);
        tick();
        flush = 1'b0; valid = 1'b0;
        check("t5_fire_post", 32'(out_fire), 0);
        check("t5_a_post", 32'(out_a), 0);
        check("t5_b_post", 32'(out_b), 0);
        check("t5_busy_post", 32'(busy), 0);
        // Two fire cycles elapsed before the flush edge took effect.
        check("t5_count_post", 32'(issued), 215);
        tick(); tick(); tick();
        check("t5_fire_later", 32'(out_fire), 0);
        check("t5_busy_later", 32'(busy), 0);

        // Test 6: asynchronous reset in the middle of an issue.
        offer(8'd3, 16'd3, 8'd5, took);
        tick(); tick(); tick();
        check("t6_fire_pre", 32'(out_fire), 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_outA", 32'(out_a), 0);
        check("t6_outB", 32'(out_b), 0);
        check("t6_fire", 32'(out_fire), 0);
        check("t6_count", 32'(issued), 0);
        check("t6_ready", 32'(ready), 0);
        check("t6_busy", 32'(busy), 0);
        tick();
        check("t6_ready_hold", 32'(ready), 0);
        rst = 1'b0;
        #1;
        check("t6_ready_rel", 32'(ready), 1);
        offer(8'd1, 16'd1, 8'd1, took);
        check("t6_accept", 32'(took), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_fire%0d", i), 32'(out_fire), (i == 2) ? 1 : 0);
            check($sformatf("t6_a%0d", i), 32'(out_a), (i == 2) ? 1 : 0);
            tick();
        end
        check("t6_count_end", 32'(issued), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bb_operand_feeder.md
Name: bb_operand_feeder

Overview:
Upstream stimulus stage for the dual-accumulator blackbox. Accepts operand pairs {a, b, repeat} over a valid/ready command stream and buffers them in a small FIFO. Drives each pair onto the accumulator inputs for `repeat` consecutive cycles, and drives zero when idle, because the accumulator adds every cycle. Also reports issue activity for the bench's scoreboard.

Parameters:
- aWidth, 8, width of operand A; matches the accumulator's aWidth.
- bWidth, 16, width of operand B; matches the accumulator's bWidth.
- depth, 4, command FIFO entries; power of two, ≥2.
- repWidth, 8, width of the repeat field.
- cntWidth, 16, width of the issued-cycle counter.

Ports:
- io_clockPin  in  1  clock; all state on its rising edge.
- io_resetPin  in  1  reset; asynchronous, active-high.
- io_flush  in  1  synchronous clear of FIFO and issue state.
- io_cmd_valid  in  1  command valid.
- io_cmd_ready  out  1  command ready.
- io_cmd_a  in  aWidth  operand A.
- io_cmd_b  in  bWidth  operand B.
- io_cmd_repeat  in  repWidth  number of issue cycles; 0 means discard.
- io_outA  out  aWidth  to accumulator io_inA; registered.
- io_outB  out  bWidth  to accumulator io_inB; registered.
- io_outFire  out  1  high while io_outA/io_outB carry a live pair; registered.
- io_busy  out  1  FIFO non-empty or issue in progress.
- io_issuedCount  out  cntWidth  total cycles with io_outFire=1; wraps.

Behaviour:
- Reset (asynchronous, active-high; clock io_clockPin):
  - FIFO empty, rem=0.
  - io_outA=0, io_outB=0, io_outFire=0, io_issuedCount=0, io_busy=0.
  - io_cmd_ready forced 0 while io_resetPin=1.
  - Takes effect immediately, including mid-issue; no partial state survives.
- Accept: a command is pushed at an edge where io_cmd_valid & io_cmd_ready.
  - io_cmd_ready = !full & !io_flush, from a registered occupancy count.
  - A command offered while not ready stays pending; the feeder holds no obligation for it.
- FIFO: no bypass. A push into an empty FIFO becomes visible to the pop logic the next cycle.
  - Simultaneous push and pop is legal whenever not full.
  - Occupancy is unchanged by a simultaneous push and pop.
- Issue FSM, state implied by rem (remaining issue cycles after the current one):
  - ISSUE (rem≠0): at the edge, hold the pair on the outputs, keep io_outFire=1, rem<=rem-1.
  - IDLE/RELOAD (rem=0), FIFO non-empty: pop the head.
    - repeat≠0: outputs <= {a,b}, io_outFire<=1, rem<=repeat-1.
    - repeat=0: outputs <= 0, io_outFire<=0; the entry is consumed and produces no issue.
  - IDLE/RELOAD (rem=0), FIFO empty: outputs <= 0, io_outFire<=0.
- Back-to-back commands issue contiguously with no bubble.
- Latency: command accepted at edge t → first io_outFire=1 visible after edge t+2, when the FIFO was empty and the feeder idle.
- Zero-drive rule: whenever io_outFire=0, io_outA and io_outB are exactly 0.
- io_issuedCount increments at every edge where the registered io_outFire is 1; modulo 2^cntWidth.
- io_flush, synchronous, takes priority over push and pop:
  - Empties the FIFO and sets rem=0.
  - io_outA/io_outB/io_outFire <= 0 at that edge.
  - io_issuedCount is retained.
  - A push offered in the flush cycle is not accepted (ready=0).
- io_busy = FIFO non-empty | rem≠0 | io_outFire.

Decomposition:
- Package bb_feeder_pkg holds:
  - the command record {a, b, repeat} and its packed width;
  - the depth-to-pointer-width constant clog2(depth).
- One sub-module: bb_cmd_fifo.
  - Synchronous FIFO with push/pop/flush.
  - Outputs: registered count, full, empty, head data.
  - Same clock and asynchronous reset.
- Issue counter, rem counter and output registers live in the top.

Test Plan:
1. Idle feeder: accept (a=3, b=5, repeat=4) at edge t.
   - io_outA=3, io_outB=5, io_outFire=1 for exactly 4 cycles starting after edge t+2; 0 otherwise.
   - io_issuedCount=4.
   - Downstream accumulator ends at outA=12, outB=20.
2. Back-to-back: (1,2,rep=1) then (7,9,rep=2) queued.
   - Outputs 1/2, 7/9, 7/9 on consecutive cycles, then 0.
   - Accumulator sums 15 and 20.
3. Fill: issue (1,1,rep=200), then push 4 more commands.
   - io_cmd_ready falls after the 4th queued accept.
   - A 5th valid command is held until the first pop after the 200-cycle issue ends.
   - No command is lost or duplicated.
4. Queue (5,5,rep=0) then (2,2,rep=1).
   - The rep=0 entry gives one cycle with fire=0 and outputs 0.
   - Next cycle outputs 2/2 once.
   - io_issuedCount increases by 1 only.
5. Flush mid-issue: during (4,4,rep=10), assert io_flush with 2 queued entries.
   - Next cycle outputs 0, fire=0, busy=0.
   - io_issuedCount retains its pre-flush value.
   - The command offered in the flush cycle is not accepted.
6. Reset mid-issue: assert io_resetPin asynchronously between edges.
   - Outputs go 0 immediately, io_issuedCount=0, ready=0 during reset.
   - After release, a fresh (1,1,rep=1) issues with the normal 2-cycle latency.
